// File: rtl/mux2_burst_arbiter.sv
// mux2_burst_arbiter
//   Round-robin burst arbiter sharing one registered 8-bit output channel
//   between requesters A and B. A requester keeps the channel for up to
//   MAX_BURST beats and then yields if the other side is waiting. Switching
//   between A and B is direct, with no IDLE cycle in between.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no owner; both grants low, sel holds its last value
//   GRANT_A | A owns the channel: gnt_a=1, sel=0
//   GRANT_B | B owns the channel: gnt_b=1, sel=1
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_a/b    requester has a byte on data_a/b (level)
//   data_a/b   requester data
//   out_ready  downstream accepts a byte this cycle (0 = stall)
//   gnt_a/b    registered, state-decoded grants
//   sel        datapath select (0 = A, 1 = B)
//   out_valid  one-cycle strobe for out_data
//   out_data   registered transferred byte
//   beat_cnt   beats completed in the current burst
module mux2_burst_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [7:0]       data_a,
  input  logic             req_b,
  input  logic [7:0]       data_b,
  input  logic             out_ready,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] beat_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t state;
  // 1 = B was served last, so A wins the next tie
  logic   last_b;

  logic beat_a;
  logic beat_b;
  logic beat;
  logic quota;

  assign beat_a = (state == GRANT_A) && req_a && out_ready;
  assign beat_b = (state == GRANT_B) && req_b && out_ready;
  assign beat   = beat_a || beat_b;
  // this beat is the last one allowed in the current burst
  assign quota  = beat && (beat_cnt == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      beat_cnt  <= '0;
    end else begin
      out_valid <= beat;
      if (beat) begin
        out_data <= beat_b ? data_b : data_a;
      end

      case (state)
        IDLE: begin
          if (req_a && (!req_b || last_b)) begin
            state    <= GRANT_A;
            gnt_a    <= 1'b1;
            gnt_b    <= 1'b0;
            sel      <= 1'b0;
            beat_cnt <= '0;
          end else if (req_b) begin
            state    <= GRANT_B;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b1;
            sel      <= 1'b1;
            beat_cnt <= '0;
          end
        end

        GRANT_A: begin
          if (!req_a || quota) begin
            last_b <= 1'b0;
            if (req_b) begin
              state    <= GRANT_B;
              gnt_a    <= 1'b0;
              gnt_b    <= 1'b1;
              sel      <= 1'b1;
              beat_cnt <= '0;
            end else if (!req_a) begin
              state    <= IDLE;
              gnt_a    <= 1'b0;
              gnt_b    <= 1'b0;
              beat_cnt <= '0;
            end else begin
              // quota reached but nobody else waiting: start a fresh burst
              beat_cnt <= '0;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        GRANT_B: begin
          if (!req_b || quota) begin
            last_b <= 1'b1;
            if (req_a) begin
              state    <= GRANT_A;
              gnt_a    <= 1'b1;
              gnt_b    <= 1'b0;
              sel      <= 1'b0;
              beat_cnt <= '0;
            end else if (!req_b) begin
              state    <= IDLE;
              gnt_a    <= 1'b0;
              gnt_b    <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= '0;
            end
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          gnt_a    <= 1'b0;
          gnt_b    <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/mux2_burst_arbiter.md
Name: mux2_burst_arbiter

Overview:
- Round-robin burst arbiter that shares one 8-bit output channel between two requesters, A and B.
- Sequences the 8-bit 2:1 select datapath: drives its select line and the per-requester grants.
- Registers the selected byte with a one-cycle valid strobe.
- Sits between two byte producers and a single downstream consumer with a stall input.

Parameters:
- MAX_BURST, 4, maximum beats one requester may transfer per grant before yielding if the other is requesting (legal range 1..255).
- CNT_W, 8, width of the internal beat counter. Must hold MAX_BURST.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A has a byte on data_a (level)
- data_a  input  8  requester A data
- req_b  input  1  requester B has a byte on data_b (level)
- data_b  input  8  requester B data
- out_ready  input  1  downstream can accept a byte this cycle (0 = stall)
- gnt_a  output  1  A owns the channel (registered, state-decoded)
- gnt_b  output  1  B owns the channel (registered, state-decoded)
- sel  output  1  datapath select: 0 = A, 1 = B
- out_valid  output  1  one-cycle strobe: out_data holds a transferred byte
- out_data  output  8  registered transferred byte
- beat_cnt  output  CNT_W  beats done in the current grant

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; gnt_a = gnt_b = 0; sel = 0; out_valid = 0; out_data = 8'h00; beat_cnt = 0.
  - Internal last_served = B, so A wins the first tie.
  - Reset mid-burst discards any in-flight beat; no out_valid is produced after release until a new beat.
- States: IDLE, GRANT_A, GRANT_B.
- Grant outputs:
  - GRANT_A gives gnt_a=1, sel=0.
  - GRANT_B gives gnt_b=1, sel=1.
  - In IDLE, both grants are 0 and sel holds its last value.
- Beat rule:
  - A beat occurs at an edge where (GRANT_A & req_a & out_ready) or (GRANT_B & req_b & out_ready).
  - On a beat: out_data <= the granted requester's data, and out_valid <= 1 for exactly the next cycle. Latency is 1 cycle from beat edge to out_valid.
  - No beat at an edge means out_valid <= 0 and out_data holds its value.
- IDLE transitions (evaluated each edge):
  - req_a & req_b: go to the grant opposite last_served.
  - Only req_a: GRANT_A. Only req_b: GRANT_B.
  - Neither: stay in IDLE.
  - No beat is possible in the IDLE cycle, so the first beat occurs no earlier than one cycle after a request.
- GRANT_X transitions (Y = the other requester):
  - req_x=0 at the edge (release): last_served <= X. If req_y, go to GRANT_Y; otherwise go to IDLE.
  - Beat that makes beat_cnt reach MAX_BURST (quota): last_served <= X. If req_y, go to GRANT_Y. Otherwise stay in GRANT_X with beat_cnt <= 0 (new burst).
  - Any other beat: beat_cnt <= beat_cnt + 1.
  - Stall (out_ready=0 with req_x=1): hold state and beat_cnt.
  - Entering any grant state clears beat_cnt to 0.
  - Switching A to B or B to A is direct, with no IDLE bubble.
- Simultaneous events:
  - A release cannot coincide with a beat, because a beat requires req_x=1.
  - A quota beat with req_y=1 always switches, even if req_x stays high.
  - With MAX_BURST=1 and both requesting, grants alternate every beat.
- Invariants:
  - gnt_a & gnt_b is never 1.
  - sel never changes while in a grant state.
  - No beat occurs without a grant.

Test Plan:
- Reset then req_a=1, data_a=8'h83, out_ready=1: gnt_a rises 1 cycle after req. Then out_valid pulses every cycle with out_data=8'h83 and sel=0. After 4 beats beat_cnt wraps to 0 and gnt_a stays asserted.
- req_a=req_b=1 from IDLE after reset, data_a=8'h83, data_b=8'hC7, MAX_BURST=4: A is granted first. Four 8'h83 beats, then the grant switches directly to B (sel=1) for four 8'hC7 beats, then back to A. No idle cycle between bursts.
- During GRANT_B after 2 beats, hold out_ready=0 for 5 cycles: no out_valid, beat_cnt holds at 2, gnt_b stays 1. Restoring out_ready completes the remaining 2 beats, then the grant passes to A if req_a=1.
- In GRANT_A after 1 beat, drop req_a with req_b=1: next cycle gnt_b=1, gnt_a=0, beat_cnt=0. With req_b=0 instead: the block goes to IDLE and sel stays 0.
- Assert rst_n=0 asynchronously (off the clock edge) mid-burst in GRANT_B: all outputs clear immediately (out_valid=0, out_data=8'h00, sel=0). After release with both requesting, A wins.
- MAX_BURST=1 with both requesting: out_data alternates 8'h83, 8'hC7, 8'h83... and sel toggles every cycle.
